// File: rtl/xoodyak_digest_collector.sv
// xoodyak_digest_collector
// Downstream stage of the Xoodyak hash core. Collects the byte stream the core
// emits into a DIGEST_BYTES-wide digest register, optionally compares it with a
// reference digest, and offers the result to a consumer over valid/ready.
// A gap counter catches a stalled core (timeout). Strobes that cannot be
// accepted are flagged as overruns, and a digest discarded by a re-arm before
// delivery is flagged as dropped. All outputs come straight from flops.

module xoodyak_digest_collector #(
    parameter int DIGEST_BYTES   = 32,    // legal range 2..64
    parameter int TIMEOUT_CYCLES = 1024   // 0 disables the timeout
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                hash_in,
    input  logic                      hash_valid,
    input  logic [8*DIGEST_BYTES-1:0] expected,
    input  logic                      expected_en,
    output logic [8*DIGEST_BYTES-1:0] digest_out,
    output logic                      digest_valid,
    input  logic                      digest_ready,
    output logic                      match,
    output logic [6:0]                byte_count,
    output logic [2:0]                err,
    output logic                      busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------

    // Error flag bit positions inside err.
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_DROPPED = 2;

    // Index of the final byte of a digest. Accepting it completes the digest.
    localparam logic [6:0] LAST_IDX = 7'(DIGEST_BYTES - 1);

    // The gap counter only has to reach TIMEOUT_CYCLES-1. A disabled timeout
    // still keeps a 1-bit counter so that the logic stays well formed.
    localparam int              GAP_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [GAP_W-1:0] GAP_LIMIT = TIMEOUT_EN ? GAP_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_MAX   = {GAP_W{1'b1}};

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,   // waiting for an arm
        S_COLLECT = 2'd1,   // accepting hash bytes
        S_HOLD    = 2'd2,   // digest complete, offered to the consumer
        S_FAULT   = 2'd3    // core stalled; only start or reset leaves
    } state_t;

    state_t                    r_state;
    logic [8*DIGEST_BYTES-1:0] r_digest;
    logic                      r_digest_valid;
    logic                      r_match;
    logic [6:0]                r_byte_count;
    logic [2:0]                r_err;
    logic                      r_busy;
    logic                      r_cmp_en;      // expected_en captured at arm
    logic [GAP_W-1:0]          r_gap;         // idle cycles since arm or last byte

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------

    logic [8*DIGEST_BYTES-1:0] w_next_digest;  // digest with hash_in written at byte_count
    logic                      w_last_byte;    // the byte in flight completes the digest
    logic                      w_match;        // compare result on the post-write digest
    logic                      w_gap_expired;  // this idle cycle ends the allowed gap
    logic [2:0]                w_arm_err;      // err value loaded by an arm

    // Digest image as it would be after writing hash_in at the current index
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        w_next_digest = r_digest;
        for (int k = 0; k < DIGEST_BYTES; k++) begin
            if (r_byte_count == 7'(k)) begin
                w_next_digest[8*k +: 8] = hash_in;
            end
        end
    end

    // Completion, compare and timeout decisions for the current cycle
    always_comb begin
        w_last_byte   = (r_byte_count == LAST_IDX);
        w_match       = r_cmp_en & (w_next_digest == expected);
        w_gap_expired = TIMEOUT_EN && (r_gap == GAP_LIMIT);
    end

    // Error flags loaded by an arm. An arm clears the flags, except for the
    // events that happen on the arming edge itself:
    //  - A strobe coinciding with start in IDLE or HOLD is an overrun.
    //  - A re-arm in HOLD without a handshake drops the pending digest.
    // During COLLECT a restart discards the byte silently. In FAULT,
    // bytes are never flagged.
    always_comb begin
        w_arm_err = 3'b000;
        case (r_state)
            S_IDLE: begin
                w_arm_err[ERR_OVERRUN] = hash_valid;
            end
            S_HOLD: begin
                w_arm_err[ERR_OVERRUN] = hash_valid;
                w_arm_err[ERR_DROPPED] = ~digest_ready;
            end
            default: begin
                w_arm_err = 3'b000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Main FSM: state plus every registered output
    // ------------------------------------------------------------------

    // Single sequential process: arm has priority in every state, then per-state behaviour
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the digest bank is a flop array driving an output, not a RAM, so it is reset with everything else.
            r_state        <= S_IDLE;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
            r_match        <= 1'b0;
            r_byte_count   <= '0;
            r_err          <= '0;
            r_busy         <= 1'b0;
            r_cmp_en       <= 1'b0;
            r_gap          <= '0;
        end else if (start) begin
            // NOTE: state uses non-blocking assignments only, so every branch reads the pre-edge values.
            // Arm, or restart, from any state. A digest still held is
            // abandoned here; w_arm_err records whether that was a drop.
            r_state        <= S_COLLECT;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
            r_match        <= 1'b0;
            r_byte_count   <= '0;
            r_err          <= w_arm_err;
            r_busy         <= 1'b1;
            r_cmp_en       <= expected_en;
            r_gap          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Nothing is armed: a strobe here is lost.
                    if (hash_valid) begin
                        r_err[ERR_OVERRUN] <= 1'b1;
                    end
                end

                S_COLLECT: begin
                    if (hash_valid) begin
                        r_digest     <= w_next_digest;
                        r_byte_count <= r_byte_count + 7'd1;
                        r_gap        <= '0;
                        if (w_last_byte) begin
                            // digest_valid and match rise together, one
                            // cycle after the final byte.
                            r_state        <= S_HOLD;
                            r_digest_valid <= 1'b1;
                            r_match        <= w_match;
                            r_busy         <= 1'b0;
                        end
                    end else if (w_gap_expired) begin
                        r_state            <= S_FAULT;
                        r_err[ERR_TIMEOUT] <= 1'b1;
                        r_busy             <= 1'b0;
                    end else if (r_gap != GAP_MAX) begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                S_HOLD: begin
                    // The digest, match and byte count stay frozen. Only the
                    // handshake or an arm ends the hold.
                    if (hash_valid) begin
                        r_err[ERR_OVERRUN] <= 1'b1;
                    end
                    if (digest_ready) begin
                        r_digest_valid <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end

                S_FAULT: begin
                    // Bytes from a core that already timed out are ignored
                    // without raising overrun.
                    r_digest_valid <= 1'b0;
                    r_busy         <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    assign digest_out   = r_digest;
    assign digest_valid = r_digest_valid;
    assign match        = r_match;
    assign byte_count   = r_byte_count;
    assign err          = r_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_xoodyak_digest_collector.sv
// Self-checking bench for xoodyak_digest_collector.
// Uses table-driven digest transactions, hand-written corner sequences, and
// randomized transactions compared against a transaction-level model.

module tb_xoodyak_digest_collector;

    localparam int DB = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [7:0]      hash_in;
    logic            hash_valid;
    logic [8*DB-1:0] expected;
    logic            expected_en;
    logic [8*DB-1:0] digest_out;
    logic            digest_valid;
    logic            digest_ready;
    logic            match;
    logic [6:0]      byte_count;
    logic [2:0]      err;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] stream_b [DB];

    xoodyak_digest_collector #(
        .DIGEST_BYTES   (DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .hash_in      (hash_in),
        .hash_valid   (hash_valid),
        .expected     (expected),
        .expected_en  (expected_en),
        .digest_out   (digest_out),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .match        (match),
        .byte_count   (byte_count),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Hard stop if something loops far beyond the expected run length.
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [8*DB-1:0] act, input logic [8*DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic en);
        start       = 1'b1;
        expected_en = en;
        hash_valid  = 1'b0;
        tick();
        start = 1'b0;
    endtask

    // Send the first n bytes of stream_b on consecutive cycles.
    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            hash_valid = 1'b1;
            hash_in    = stream_b[i];
            tick();
        end
        hash_valid = 1'b0;
    endtask

    function automatic logic [8*DB-1:0] pack_stream();
        logic [8*DB-1:0] r;
        for (int k = 0; k < DB; k++) r[8*k +: 8] = stream_b[k];
        return r;
    endfunction

    function automatic logic [8*DB-1:0] ascending();
        logic [8*DB-1:0] r;
        for (int k = 0; k < DB; k++) r[8*k +: 8] = 8'(k);
        return r;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " digest_out"},   digest_out,   '0);
        check({tag, " digest_valid"}, digest_valid, '0);
        check({tag, " match"},        match,        '0);
        check({tag, " byte_count"},   byte_count,   '0);
        check({tag, " err"},          err,          '0);
        check({tag, " busy"},         busy,         '0);
    endtask

    typedef struct {
        logic       en;
        int         bad_idx;      // -1: no corrupted byte
        logic [7:0] bad_val;
        int         ready_delay;  // cycles digest_ready stays low after valid
        logic       exp_match;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [8*DB-1:0] exp_digest;
        logic [8*DB-1:0] exp_vec;
        logic            en;
        logic            model_match;
        int              idx;
        int              gap;
        int              d;

        reset        = 1'b1;
        start        = 1'b0;
        hash_in      = 8'h00;
        hash_valid   = 1'b0;
        expected     = '0;
        expected_en  = 1'b0;
        digest_ready = 1'b0;

        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // ---------------- table-driven digests ----------------
        vecs[0] = '{en: 1'b1, bad_idx: -1, bad_val: 8'h00, ready_delay: 0,  exp_match: 1'b1};
        vecs[1] = '{en: 1'b1, bad_idx: 17, bad_val: 8'hAA, ready_delay: 10, exp_match: 1'b0};
        vecs[2] = '{en: 1'b0, bad_idx: -1, bad_val: 8'h00, ready_delay: 0,  exp_match: 1'b0};
        vecs[3] = '{en: 1'b1, bad_idx: 31, bad_val: 8'hFF, ready_delay: 2,  exp_match: 1'b0};
        vecs[4] = '{en: 1'b1, bad_idx: 0,  bad_val: 8'h00, ready_delay: 1,  exp_match: 1'b1};

        expected = ascending();
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < DB; k++)
                stream_b[k] = (k == vecs[v].bad_idx) ? vecs[v].bad_val : 8'(k);
            exp_digest   = pack_stream();
            digest_ready = (vecs[v].ready_delay == 0);
            arm(vecs[v].en);
            check($sformatf("vec%0d busy after arm", v), busy, 1'b1);
            check($sformatf("vec%0d count after arm", v), byte_count, 7'd0);
            send_bytes(DB - 1);
            check($sformatf("vec%0d valid before last", v), digest_valid, 1'b0);
            send_bytes_last: begin
                hash_valid = 1'b1;
                hash_in    = stream_b[DB-1];
                tick();
                hash_valid = 1'b0;
            end
            check($sformatf("vec%0d valid", v),  digest_valid, 1'b1);
            check($sformatf("vec%0d digest", v), digest_out,   exp_digest);
            check($sformatf("vec%0d match", v),  match,        vecs[v].exp_match);
            check($sformatf("vec%0d count", v),  byte_count,   7'd32);
            check($sformatf("vec%0d err", v),    err,          3'b000);
            check($sformatf("vec%0d busy", v),   busy,         1'b0);
            for (int c = 0; c < vecs[v].ready_delay; c++) begin
                tick();
                check($sformatf("vec%0d hold valid c%0d", v, c),  digest_valid, 1'b1);
                check($sformatf("vec%0d hold digest c%0d", v, c), digest_out,   exp_digest);
                check($sformatf("vec%0d hold match c%0d", v, c),  match,        vecs[v].exp_match);
            end
            digest_ready = 1'b1;
            tick();
            digest_ready = 1'b0;
            check($sformatf("vec%0d valid after ready", v),  digest_valid, 1'b0);
            check($sformatf("vec%0d digest retained", v),    digest_out,   exp_digest);
            check($sformatf("vec%0d busy after ready", v),   busy,         1'b0);
        end

        // ---------------- timeout into FAULT ----------------
        for (int k = 0; k < DB; k++) stream_b[k] = 8'(k);
        arm(1'b1);
        send_bytes(5);
        repeat (TO - 1) tick();
        check("timeout busy before limit", busy, 1'b1);
        check("timeout err before limit",  err,  3'b000);
        tick();
        check("timeout busy", busy, 1'b0);
        check("timeout err",  err,  3'b001);
        check("timeout valid", digest_valid, 1'b0);
        hash_valid = 1'b1;
        hash_in    = 8'h33;
        tick();
        hash_valid = 1'b0;
        check("fault byte no overrun", err, 3'b001);
        arm(1'b0);
        check("rearm from fault err",  err,  3'b000);
        check("rearm from fault busy", busy, 1'b1);

        // ---------------- overrun and drop in HOLD ----------------
        arm(1'b0);
        send_bytes(DB);
        exp_digest = pack_stream();
        check("hold valid", digest_valid, 1'b1);
        hash_valid = 1'b1;
        hash_in    = 8'h55;
        tick();
        hash_valid = 1'b0;
        check("hold overrun err",    err,          3'b010);
        check("hold overrun digest", digest_out,   exp_digest);
        check("hold overrun valid",  digest_valid, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("drop err2",   {255'd0, err[2]}, 1'b1);
        check("drop valid",  digest_valid, 1'b0);
        check("drop count",  byte_count,   7'd0);
        check("drop busy",   busy,         1'b1);

        // ---------------- asynchronous reset mid-collect ----------------
        arm(1'b1);
        send_bytes(10);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async reset");
        #1;
        reset = 1'b0;
        tick();
        expected = ascending();
        arm(1'b1);
        send_bytes(DB);
        check("post reset valid",  digest_valid, 1'b1);
        check("post reset digest", digest_out,   ascending());
        check("post reset match",  match,        1'b1);
        check("post reset err",    err,          3'b000);
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;

        // ---------------- start and strobe together in IDLE ----------------
        start      = 1'b1;
        hash_valid = 1'b1;
        hash_in    = 8'h77;
        tick();
        start      = 1'b0;
        hash_valid = 1'b0;
        check("idle start+valid err",   err,        3'b010);
        check("idle start+valid busy",  busy,       1'b1);
        check("idle start+valid count", byte_count, 7'd0);
        repeat (3) tick();
        check("overrun sticky", err, 3'b010);
        arm(1'b0);
        check("arm clears overrun", err, 3'b000);

        // Strobe alone in IDLE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hash_valid = 1'b1;
        tick();
        hash_valid = 1'b0;
        check("idle strobe err",  err,  3'b010);
        check("idle strobe busy", busy, 1'b0);

        // ---------------- randomized transactions ----------------
        for (int t = 0; t < 20; t++) begin
            en = 1'($urandom_range(0, 1));
            for (int k = 0; k < DB; k++) stream_b[k] = 8'($urandom);
            exp_digest = pack_stream();
            exp_vec    = exp_digest;
            if ($urandom_range(0, 1) == 0) begin
                idx = $urandom_range(0, DB - 1);
                exp_vec[8*idx +: 8] = exp_vec[8*idx +: 8] ^ 8'($urandom_range(1, 255));
            end
            expected     = exp_vec;
            model_match  = en && (exp_vec == exp_digest);
            digest_ready = 1'b0;
            arm(en);
            for (int i = 0; i < DB; i++) begin
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : 0;
                hash_valid = 1'b0;
                repeat (gap) tick();
                hash_valid = 1'b1;
                hash_in    = stream_b[i];
                tick();
                check($sformatf("rnd%0d count b%0d", t, i), byte_count, 7'(i + 1));
                check($sformatf("rnd%0d valid b%0d", t, i), digest_valid, (i == DB - 1));
            end
            hash_valid = 1'b0;
            check($sformatf("rnd%0d digest", t), digest_out, exp_digest);
            check($sformatf("rnd%0d match", t),  match,      model_match);
            check($sformatf("rnd%0d err", t),    err,        3'b000);
            d = $urandom_range(0, 4);
            repeat (d) tick();
            check($sformatf("rnd%0d valid held", t), digest_valid, 1'b1);
            digest_ready = 1'b1;
            tick();
            digest_ready = 1'b0;
            check($sformatf("rnd%0d valid after ready", t), digest_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xoodyak_digest_collector.md
Name: xoodyak_digest_collector

Overview:
- Downstream stage of the Xoodyak hash core.
- Captures the byte stream the core emits (hash byte plus per-cycle valid strobe) and assembles a DIGEST_BYTES-wide digest register.
- Compares the finished digest against an optional expected value.
- Hands the digest to the consumer (bus wrapper or self-test logic) over a valid/ready handshake, with timeout and overrun detection.

Parameters:
- DIGEST_BYTES, 32, number of hash bytes collected per digest; must be 2..64.
- TIMEOUT_CYCLES, 1024, maximum cycles allowed between arm/byte and the next byte before flagging a timeout; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  same start pulse given to the hash core; arms collection.
- hash_in  in  8  hash byte from the core.
- hash_valid  in  1  hash_in is valid this cycle. No backpressure: every strobe must be accepted or flagged.
- expected  in  8*DIGEST_BYTES  reference digest, byte k at bits [8k+7:8k].
- expected_en  in  1  sampled at start; 1 = perform compare.
- digest_out  out  8*DIGEST_BYTES  assembled digest, byte k at bits [8k+7:8k].
- digest_valid  out  1  digest_out/match are final.
- digest_ready  in  1  consumer accepts the digest.
- match  out  1  digest equals expected (0 when compare disabled).
- byte_count  out  7  bytes captured in the current digest.
- err  out  3  sticky flags: [0] timeout, [1] overrun, [2] dropped (undelivered digest discarded).
- busy  out  1  state is COLLECT.

Behaviour:
- Reset: all outputs 0; state IDLE; compare-enable latch 0; gap counter 0.
- States: IDLE, COLLECT, HOLD, FAULT.
- IDLE:
  - start=1 -> COLLECT next cycle. On that edge: digest_out<=0, byte_count<=0, err<=0, gap counter<=0, latch expected_en.
  - hash_valid=1 without start -> byte discarded, err[1]<=1.
  - start and hash_valid in the same cycle -> start wins, byte discarded, err[1]<=1.
- COLLECT, on hash_valid:
  - digest_out[8*byte_count +: 8] <= hash_in.
  - byte_count <= byte_count+1.
  - gap counter <= 0.
- COLLECT completion: when the accepted byte is index DIGEST_BYTES-1, the same edge moves to HOLD and sets digest_valid<=1.
  - match <= (next digest == expected) & latched enable, computed combinationally on the post-write value and registered.
  - digest_valid and match therefore rise together, 1 cycle after the last byte.
- COLLECT, no hash_valid: gap counter increments, saturating.
  - When it reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0) -> FAULT, err[0]<=1.
- COLLECT, start=1: restart, same clears as the IDLE arm; state stays COLLECT; any byte in that cycle is discarded.
- HOLD:
  - digest_out, match and byte_count are frozen; digest_valid stays 1 until the cycle digest_ready=1.
  - On that edge: digest_valid<=0 -> IDLE. Digest contents are retained until the next arm.
  - hash_valid in HOLD -> discarded, err[1]<=1.
  - start in HOLD without digest_ready -> err[2]<=1, digest_valid<=0, arm as from IDLE.
  - start with digest_ready in the same cycle -> handshake completes (no err[2]), then arm.
- FAULT:
  - busy=0, digest_valid=0; bytes discarded without setting err[1].
  - Only start (re-arm, clears err) or reset leaves FAULT.
- byte_count never exceeds DIGEST_BYTES; no wrap-around.
- Reset asserted mid-COLLECT or mid-HOLD: immediate return to reset values; partial digest lost.
- busy = (state==COLLECT), registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, start with expected_en=1 and expected bytes 0x00..0x1F; drive hash_in=k for k=0..31 on consecutive valid cycles, digest_ready=1 -> digest_valid for exactly 1 cycle starting 1 cycle after byte 31; digest_out byte k = k; match=1; err=0; byte_count=32.
- Same stream with byte 17 = 0xAA and expected_en=1 -> match=0, digest_valid=1. Hold digest_ready=0 for 10 cycles -> outputs stable; ready=1 -> IDLE next cycle.
- Arm, send 5 bytes, then idle TIMEOUT_CYCLES=16 (override) -> FAULT after 16 gap cycles, err=3'b001, busy=0. Next start -> err=0, busy=1.
- Complete a digest; hold digest_ready=0; pulse hash_valid with 0x55 -> err[1]=1, digest_out unchanged. Pulse start -> err[2]=1, digest_valid=0, byte_count=0.
- Assert reset asynchronously after 10 of 32 bytes (mid-cycle) -> all outputs 0 immediately. Re-arm and send 32 bytes -> clean digest, err=0.
- hash_valid and start together in IDLE -> byte discarded, err[1]=1 until the following arm clears it.
